fc_layer_sequencer: RTL and testbench

- Controller for one fully connected layer of neuron instances. All neurons in the layer share one weight-config bus and one input bus.
- After reset it streams weights from a config stream into each neuron in turn. It then broadcasts each NUM_WEIGHT-element input vector to all neurons and collects every neuron's activation.
- It emits the activations as an output stream for the next layer.
- It sits between the previous layer (or host DMA) and the bank of neuron instances.

---
 rtl/fc_ctrl_pkg.sv | 15 +
 rtl/fc_result_buffer.sv | 66 ++++++
 rtl/fc_layer_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_ctrl_pkg.sv
// Shared types and constants for the fully connected layer controller.
package fc_ctrl_pkg;

    // Weight word / config bus width
    localparam int CFG_WIDTH = 32;

    // Sequencer phases: weight load, input broadcast, result collect, result drain
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FEED  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fc_seq_state_t;

endpackage

// File: rtl/fc_result_buffer.sv
// Per-neuron activation capture registers with a done mask and a read mux.
// A neuron's first result per vector is kept. Later pulses for that neuron
// only raise dup_err.
module fc_result_buffer
    import fc_ctrl_pkg::*;
#(
    parameter int NUM_NEURON = 10,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = $clog2(NUM_NEURON + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cap_en,
    input  logic                                  clr,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0]      neuron_out,
    input  logic [NUM_NEURON-1:0]                 neuron_outvalid,
    input  logic [IDX_W-1:0]                      rd_idx,
    output logic [DATA_WIDTH-1:0]                 rd_data,
    output logic [NUM_NEURON-1:0]                 done,
    output logic                                  all_done,
    output logic                                  dup_err
);

    logic [NUM_NEURON-1:0][DATA_WIDTH-1:0] res_in;
    logic [NUM_NEURON-1:0][DATA_WIDTH-1:0] res_q;
    logic [NUM_NEURON-1:0]                 cap;

    assign res_in = neuron_out;
    assign cap    = neuron_outvalid & {NUM_NEURON{cap_en}};

    for (genvar i = 0; i < NUM_NEURON; i++) begin : g_entry
        logic [DATA_WIDTH-1:0] ent_q;
        logic                  dn_q;

        // Capture the first result of this neuron and track that it arrived
        always_ff @(posedge clk) begin
            if (rst) begin
                ent_q <= '0;
                dn_q  <= 1'b0;
            end else begin
                if (cap[i] && !dn_q)
                    ent_q <= res_in[i];
                if (clr)
                    dn_q <= 1'b0;
                else if (cap[i])
                    dn_q <= 1'b1;
            end
        end

        assign res_q[i] = ent_q;
        assign done[i]  = dn_q;
    end

    // All-done counts captures happening this very cycle
    assign all_done = &(done | cap);
    assign dup_err  = |(done & cap);

    // Read mux; indices past the last neuron read as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_NEURON; i++)
            if (rd_idx == IDX_W'(i))
                rd_data = res_q[i];
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Fully connected layer controller: loads weights into each neuron in turn,
// broadcasts input vectors, gathers activations and streams them out.
module fc_layer_sequencer
    import fc_ctrl_pkg::*;
#(
    parameter int LAYER_NO    = 3,
    parameter int NUM_NEURON  = 10,
    parameter int NEURON_BASE = 0,
    parameter int NUM_WEIGHT  = 10,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [CFG_WIDTH-1:0]               cfg_data,
    output logic                               weight_valid,
    output logic [CFG_WIDTH-1:0]               weight_value,
    output logic [CFG_WIDTH-1:0]               config_layer_num,
    output logic [CFG_WIDTH-1:0]               config_neuron_num,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic [DATA_WIDTH-1:0]              neuron_in,
    output logic                               neuron_in_valid,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0]   neuron_out,
    input  logic [NUM_NEURON-1:0]              neuron_outvalid,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_last,
    output logic                               weights_loaded,
    output logic                               err
);

    localparam int EW = $clog2(NUM_WEIGHT + 1);
    localparam int NW = $clog2(NUM_NEURON + 1);
    localparam logic [EW-1:0] W_LAST = EW'(NUM_WEIGHT - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURON - 1);

    fc_seq_state_t state_q, state_d;

    logic [EW-1:0]         w_cnt;
    logic [NW-1:0]         n_idx;
    logic [EW-1:0]         elem_cnt;
    logic [NW-1:0]         out_idx;
    logic [NW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [NUM_NEURON-1:0] done;
    logic                  all_done;
    logic                  dup_err;
    logic                  cfg_acc;
    logic                  in_acc;
    logic                  out_acc;
    logic                  go_drain;

    assign config_layer_num = CFG_WIDTH'(LAYER_NO);

    assign cfg_acc  = cfg_valid & cfg_ready;
    assign in_acc   = in_valid & in_ready;
    assign out_acc  = (state_q == DRAIN) & out_valid & out_ready;
    assign go_drain = (state_q == WAIT) & all_done;

    // Look one entry ahead on an accepted beat so the next word is ready
    assign rd_idx = out_acc ? NW'(out_idx + 1'b1) : out_idx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // Next-state and stream readies
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        unique case (state_q)
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_acc && w_cnt == W_LAST && n_idx == N_LAST)
                    state_d = FEED;
            end
            FEED: begin
                in_ready = (elem_cnt < EW'(NUM_WEIGHT));
                if (in_acc && elem_cnt == W_LAST)
                    state_d = WAIT;
            end
            WAIT: begin
                if (all_done)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (out_acc && out_idx == N_LAST)
                    state_d = FEED;
            end
            default: state_d = LOAD;
        endcase
    end

    // Weight streaming: one weight per accepted config beat, neuron by neuron
    always_ff @(posedge clk) begin
        if (rst) begin
            w_cnt             <= '0;
            n_idx             <= '0;
            weight_valid      <= 1'b0;
            weight_value      <= '0;
            config_neuron_num <= '0;
            weights_loaded    <= 1'b0;
        end else begin
            weight_valid <= cfg_acc;
            if (cfg_acc) begin
                weight_value      <= cfg_data;
                config_neuron_num <= CFG_WIDTH'(NEURON_BASE) + CFG_WIDTH'(n_idx);
                if (w_cnt == W_LAST) begin
                    w_cnt <= '0;
                    if (n_idx == N_LAST)
                        weights_loaded <= 1'b1;
                    else
                        n_idx <= n_idx + 1'b1;
                end else begin
                    w_cnt <= w_cnt + 1'b1;
                end
            end
        end
    end

    // Input broadcast: each accepted element is presented to all neurons once
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_cnt        <= '0;
            neuron_in       <= '0;
            neuron_in_valid <= 1'b0;
        end else begin
            neuron_in_valid <= in_acc;
            if (in_acc) begin
                neuron_in <= in_data;
                elem_cnt  <= (elem_cnt == W_LAST) ? '0 : elem_cnt + 1'b1;
            end
        end
    end

    // Output drain: first DRAIN cycle loads beat 0, then advance on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (state_q == DRAIN) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
                out_last  <= (out_idx == N_LAST);
            end else if (out_ready) begin
                if (out_idx == N_LAST) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_idx   <= '0;
                end else begin
                    out_idx  <= rd_idx;
                    out_data <= rd_data;
                    out_last <= (rd_idx == N_LAST);
                end
            end
        end
    end

    // Sticky error: duplicate result in WAIT, or any result outside WAIT
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if ((state_q == WAIT && dup_err) || (state_q != WAIT && |neuron_outvalid))
            err <= 1'b1;
    end

    fc_result_buffer #(
        .NUM_NEURON (NUM_NEURON),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (NW)
    ) u_res_buf (
        .clk             (clk),
        .rst             (rst),
        .cap_en          (state_q == WAIT),
        .clr             (go_drain),
        .neuron_out      (neuron_out),
        .neuron_outvalid (neuron_outvalid),
        .rd_idx          (rd_idx),
        .rd_data         (rd_data),
        .done            (done),
        .all_done        (all_done),
        .dup_err         (dup_err)
    );

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with two neurons of three weights.
module tb_fc_layer_sequencer;

    localparam int NN = 2;
    localparam int NWT = 3;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [31:0]     cfg_data;
    logic            weight_valid;
    logic [31:0]     weight_value;
    logic [31:0]     config_layer_num;
    logic [31:0]     config_neuron_num;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [DW-1:0]   neuron_in;
    logic            neuron_in_valid;
    logic [NN*DW-1:0] neuron_out;
    logic [NN-1:0]   neuron_outvalid;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            weights_loaded;
    logic            err;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    fc_layer_sequencer #(
        .LAYER_NO    (3),
        .NUM_NEURON  (NN),
        .NEURON_BASE (0),
        .NUM_WEIGHT  (NWT),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_data          (cfg_data),
        .weight_valid      (weight_valid),
        .weight_value      (weight_value),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .neuron_in         (neuron_in),
        .neuron_in_valid   (neuron_in_valid),
        .neuron_out        (neuron_out),
        .neuron_outvalid   (neuron_outvalid),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .weights_loaded    (weights_loaded),
        .err               (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int max);
        int n = 0;
        while (!out_valid && n < max) begin
            step();
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; in_valid = 1'b0; in_data = '0;
        neuron_out = '0; neuron_outvalid = '0; out_ready = 1'b0;
        step(); step();

        // Reset state
        check("rst_weight_valid", 32'(weight_valid), 32'd0);
        check("rst_weights_loaded", 32'(weights_loaded), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_niv", 32'(neuron_in_valid), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("layer_num", config_layer_num, 32'd3);
        rst = 1'b0;

        // Weight load: six words back to back
        cfg_valid = 1'b1; cfg_data = 32'd1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("load_wv", 32'(weight_valid), 32'd1);
            check("load_wval", weight_value, 32'(k));
            check("load_neuron", config_neuron_num, 32'((k - 1) / 3));
            if (k < 6) cfg_data = 32'(k + 1);
            else       cfg_valid = 1'b0;
        end
        check("loaded", 32'(weights_loaded), 32'd1);
        check("load_cfg_ready_off", 32'(cfg_ready), 32'd0);
        check("feed_in_ready", 32'(in_ready), 32'd1);
        step();
        check("load_wv_off", 32'(weight_valid), 32'd0);

        // Feed 5, gap of two cycles, 6, 7
        in_valid = 1'b1; in_data = 16'd5;
        step();
        check("feed_niv5", 32'(neuron_in_valid), 32'd1);
        check("feed_ni5", 32'(neuron_in), 32'd5);
        in_valid = 1'b0;
        step();
        check("feed_gap1", 32'(neuron_in_valid), 32'd0);
        step();
        check("feed_gap2", 32'(neuron_in_valid), 32'd0);
        in_valid = 1'b1; in_data = 16'd6;
        step();
        check("feed_niv6", 32'(neuron_in_valid), 32'd1);
        check("feed_ni6", 32'(neuron_in), 32'd6);
        in_data = 16'd7;
        step();
        check("feed_niv7", 32'(neuron_in_valid), 32'd1);
        check("feed_ni7", 32'(neuron_in), 32'd7);
        check("feed_in_ready_off", 32'(in_ready), 32'd0);
        in_data = 16'd9;
        step();
        check("wait_in_ignored", 32'(neuron_in_valid), 32'd0);
        in_valid = 1'b0;

        // Staggered results: neuron 1 first, neuron 0 three cycles later
        neuron_outvalid = 2'b10; neuron_out = {16'h0ABC, 16'h0000};
        step();
        neuron_outvalid = 2'b00; neuron_out = '0;
        step(); step();
        neuron_outvalid = 2'b01; neuron_out = {16'hFFFF, 16'h0123};
        step();
        neuron_outvalid = 2'b00; neuron_out = '0;
        check("clean_err", 32'(err), 32'd0);

        // Drain with four stall cycles on the first beat
        wait_out(8);
        check("drain0_data", 32'(out_data), 32'h0123);
        check("drain0_last", 32'(out_last), 32'd0);
        for (int s = 0; s < 4; s++) begin
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'h0123);
        end
        out_ready = 1'b1;
        step();
        check("drain1_valid", 32'(out_valid), 32'd1);
        check("drain1_data", 32'(out_data), 32'h0ABC);
        check("drain1_last", 32'(out_last), 32'd1);
        step();
        check("drain_done_valid", 32'(out_valid), 32'd0);
        check("back_to_feed", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Result pulse while in FEED
        neuron_outvalid = 2'b10; neuron_out = {16'h5555, 16'h0000};
        step();
        neuron_outvalid = 2'b00; neuron_out = '0;
        check("feed_pulse_err", 32'(err), 32'd1);

        in_valid = 1'b1;
        for (int d = 1; d <= 3; d++) begin
            in_data = 16'(d);
            step();
        end
        in_valid = 1'b0;
        check("feed2_in_ready_off", 32'(in_ready), 32'd0);

        // Duplicate pulse on neuron 0; first value must win
        neuron_outvalid = 2'b01; neuron_out = {16'h0000, 16'h1111};
        step();
        neuron_out = {16'h0000, 16'h2222};
        step();
        neuron_outvalid = 2'b10; neuron_out = {16'h3333, 16'h0000};
        step();
        neuron_outvalid = 2'b00; neuron_out = '0;
        out_ready = 1'b1;
        wait_out(8);
        check("dup_data0", 32'(out_data), 32'h1111);
        check("dup_last0", 32'(out_last), 32'd0);
        step();
        check("dup_data1", 32'(out_data), 32'h3333);
        check("dup_last1", 32'(out_last), 32'd1);
        step();
        check("dup_drain_done", 32'(out_valid), 32'd0);
        check("err_sticky", 32'(err), 32'd1);
        out_ready = 1'b0;

        // Reset in the middle of a vector
        in_valid = 1'b1; in_data = 16'd4;
        step();
        in_data = 16'd8;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check("mrst_loaded", 32'(weights_loaded), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        check("mrst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("mrst_err", 32'(err), 32'd0);
        check("mrst_niv", 32'(neuron_in_valid), 32'd0);
        check("mrst_ni", 32'(neuron_in), 32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data", 32'(out_data), 32'd0);
        check("mrst_wv", 32'(weight_valid), 32'd0);
        check("mrst_neuron", config_neuron_num, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
